// File: rtl/ticks_to_bcd_pkg.sv
// Shared types and defaults for the reaction-time formatter (r0_fmt_pkg).
package r0_fmt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        ROUND,
        BCD,
        DONE
    } fmt_state_t;

    localparam int TICKS_PER_MS_DEF = 50000;
    localparam int TICK_W_DEF       = 28;
    localparam int DIGITS_DEF       = 4;
    localparam int Q_W_DEF          = 14;

    localparam logic [TICK_W_DEF-1:0] TICK_SENTINEL = '1;

    // Largest value representable with the given number of decimal digits.
    function automatic int ms_max(input int digits);
        int r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

    localparam int MS_MAX = ms_max(DIGITS_DEF);

endpackage

// File: rtl/bcd_dabble.sv
// Shift-add-3 binary to packed BCD engine; load primes it, each step does one add-3 pass plus shift.
module bcd_dabble
    import r0_fmt_pkg::*;
#(
    parameter int BIN_W  = Q_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [DIGITS*4-1:0]   digits_next
);

    logic [DIGITS*4-1:0]       bcd;
    logic [BIN_W-1:0]          bin;
    logic [DIGITS*4-1:0]       adj;
    logic [DIGITS*4+BIN_W-1:0] shifted;
    logic [BIN_W-1:0]          bin_next;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        shifted     = {adj, bin} << 1;
        digits_next = shifted[DIGITS*4+BIN_W-1:BIN_W];
        bin_next    = shifted[BIN_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd <= '0;
            bin <= '0;
        end else if (load) begin
            bcd <= '0;
            bin <= bin_in;
        end else if (step) begin
            bcd <= digits_next;
            bin <= bin_next;
        end
    end

endmodule

// File: rtl/ticks_to_bcd.sv
// Tick count -> milliseconds (restoring divide) -> packed BCD, with sentinel and saturation.
// Define ROUND_HALF_EN to round the millisecond value half-up instead of truncating.
module ticks_to_bcd
    import r0_fmt_pkg::*;
#(
    parameter int TICK_W       = TICK_W_DEF,
    parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
    parameter int DIGITS       = DIGITS_DEF,
    parameter int Q_W          = Q_W_DEF
) (
    input  logic                 i_clk_50m,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [TICK_W-1:0]    i_ticks,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [DIGITS*4-1:0]  o_digits,
    output logic                 o_ovf,
    output logic                 o_none
);

    localparam int R_W   = $clog2(TICKS_PER_MS) + 1;
    localparam int CNT_W = $clog2((TICK_W > Q_W) ? TICK_W : Q_W) + 1;

    localparam logic [R_W-1:0]  DIVISOR  = R_W'(TICKS_PER_MS);
    localparam logic [TICK_W:0] MAX_Q    = (TICK_W+1)'(ms_max(DIGITS));
    localparam logic [Q_W-1:0]  MAX_LOAD = Q_W'(ms_max(DIGITS));
`ifdef ROUND_HALF_EN
    localparam logic [R_W-1:0]  HALF     = R_W'(TICKS_PER_MS / 2);
`endif

    fmt_state_t          state;
    logic [TICK_W-1:0]   dividend;
    logic [TICK_W-1:0]   quo;
    logic [R_W-1:0]      rem;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_flag;

    logic [R_W:0]        rem_shift;
    logic                ge;
    logic [R_W-1:0]      rem_next;
    logic [TICK_W-1:0]   quo_next;
    logic [TICK_W:0]     final_q;
    logic                sat;
    logic [Q_W-1:0]      load_val;
    logic                dab_load;
    logic                dab_step;
    logic [DIGITS*4-1:0] digits_next;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem, dividend[TICK_W-1]};
        ge        = rem_shift >= {1'b0, DIVISOR};
        rem_next  = R_W'(ge ? rem_shift - {1'b0, DIVISOR} : rem_shift);
        quo_next  = {quo[TICK_W-2:0], ge};
`ifdef ROUND_HALF_EN
        final_q   = {1'b0, quo} + (TICK_W+1)'(rem >= HALF);
        dab_load  = (state == ROUND);
`else
        // The last quotient bit is still combinational when the engine is loaded.
        final_q   = {quo, ge};
        dab_load  = (state == DIV) && (cnt == '0);
`endif
        sat       = final_q > MAX_Q;
        load_val  = sat ? MAX_LOAD : final_q[Q_W-1:0];
        dab_step  = (state == BCD);
    end

    bcd_dabble #(
        .BIN_W  (Q_W),
        .DIGITS (DIGITS)
    ) u_dabble (
        .clk         (i_clk_50m),
        .rst_n       (i_rst_n),
        .load        (dab_load),
        .step        (dab_step),
        .bin_in      (load_val),
        .digits_next (digits_next)
    );

    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_digits <= '0;
            o_ovf    <= 1'b0;
            o_none   <= 1'b0;
            dividend <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy <= 1'b1;
                        if (i_ticks == '1) begin
                            state    <= DONE;
                            o_valid  <= 1'b1;
                            o_digits <= '1;
                            o_ovf    <= 1'b0;
                            o_none   <= 1'b1;
                        end else begin
                            dividend <= i_ticks;
                            rem      <= '0;
                            quo      <= '0;
                            cnt      <= CNT_W'(TICK_W - 1);
                            state    <= DIV;
                        end
                    end
                end
                DIV: begin
                    dividend <= {dividend[TICK_W-2:0], 1'b0};
                    rem      <= rem_next;
                    quo      <= quo_next;
                    cnt      <= cnt - 1'b1;
                    if (cnt == '0) begin
`ifdef ROUND_HALF_EN
                        state    <= ROUND;
`else
                        state    <= BCD;
                        cnt      <= CNT_W'(Q_W - 1);
                        ovf_flag <= sat;
`endif
                    end
                end
`ifdef ROUND_HALF_EN
                ROUND: begin
                    state    <= BCD;
                    cnt      <= CNT_W'(Q_W - 1);
                    ovf_flag <= sat;
                end
`endif
                BCD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state    <= DONE;
                        o_valid  <= 1'b1;
                        o_digits <= digits_next;
                        o_ovf    <= ovf_flag;
                        o_none   <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ticks_to_bcd.sv
// Directed vector bench for ticks_to_bcd (default 4-digit instance plus a 3-digit instance).
module tb_ticks_to_bcd;
    import r0_fmt_pkg::*;

`ifdef ROUND_HALF_EN
    localparam int LAT4 = 44;
    localparam int LAT3 = 40;
`else
    localparam int LAT4 = 43;
    localparam int LAT3 = 39;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start3;
    logic [27:0] ticks, ticks3;
    logic        busy, valid, ovf, none;
    logic [15:0] digits;
    logic        busy3, valid3, ovf3, none3;
    logic [11:0] digits3;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    ticks_to_bcd dut (
        .i_clk_50m (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_ticks   (ticks),
        .o_busy    (busy),
        .o_valid   (valid),
        .o_digits  (digits),
        .o_ovf     (ovf),
        .o_none    (none)
    );

    ticks_to_bcd #(.DIGITS(3), .Q_W(10)) dut3 (
        .i_clk_50m (clk),
        .i_rst_n   (rst_n),
        .i_start   (start3),
        .i_ticks   (ticks3),
        .o_busy    (busy3),
        .o_valid   (valid3),
        .o_digits  (digits3),
        .o_ovf     (ovf3),
        .o_none    (none3)
    );

    typedef struct {
        bit          sel;
        logic [27:0] ticks;
        logic [15:0] digits;
        bit          ovf;
        bit          none;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one start pulse; returns on the falling edge just after the accepting edge.
    task automatic applyStimulus(input bit sel, input logic [27:0] t);
        @(negedge clk);
        if (sel) begin
            start3 = 1'b1;
            ticks3 = t;
        end else begin
            start  = 1'b1;
            ticks  = t;
        end
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
        ticks  = '0;
        ticks3 = '0;
    endtask

    task automatic runConversion(input string name, input bit sel, input logic [27:0] t,
                                 input logic [15:0] exp_digits, input bit exp_ovf,
                                 input bit exp_none, input int exp_lat);
        int          lat;
        bit          busy_ok;
        logic [15:0] got;
        lat     = -1;
        busy_ok = 1'b1;
        applyStimulus(sel, t);
        for (int k = 1; k <= 120; k++) begin
            if (k > 1) @(negedge clk);
            if (!(sel ? busy3 : busy)) busy_ok = 1'b0;
            if (sel ? valid3 : valid) begin
                lat = k;
                break;
            end
        end
        got = sel ? {4'h0, digits3} : digits;
        checkOutput({name, " latency"}, lat, exp_lat);
        checkOutput({name, " busy"}, busy_ok, 1'b1);
        checkOutput({name, " digits"}, got, exp_digits);
        checkOutput({name, " ovf"}, sel ? ovf3 : ovf, exp_ovf);
        checkOutput({name, " none"}, sel ? none3 : none, exp_none);
        @(negedge clk);
        checkOutput({name, " valid pulse"}, sel ? valid3 : valid, 1'b0);
        checkOutput({name, " busy after"}, sel ? busy3 : busy, 1'b0);
        repeat (3) @(negedge clk);
        got = sel ? {4'h0, digits3} : digits;
        checkOutput({name, " hold"}, got, exp_digits);
    endtask

    initial begin
        int          valid_count;
        int          first_lat;
        logic [15:0] first_digits;

`ifdef ROUND_HALF_EN
        vecs[0]  = '{0, 28'd12_500_000,  16'h0250, 0, 0, LAT4};
        vecs[1]  = '{0, 28'd49_999,      16'h0001, 0, 0, LAT4};
        vecs[2]  = '{0, 28'd50_000,      16'h0001, 0, 0, LAT4};
        vecs[3]  = '{0, 28'd268_435_454, 16'h5369, 0, 0, LAT4};
        vecs[4]  = '{0, 28'd25_000,      16'h0001, 0, 0, LAT4};
        vecs[5]  = '{0, 28'd24_999,      16'h0000, 0, 0, LAT4};
        vecs[6]  = '{0, 28'd0,           16'h0000, 0, 0, LAT4};
        vecs[7]  = '{0, 28'd123_456_789, 16'h2469, 0, 0, LAT4};
        vecs[8]  = '{0, 28'd99_975_000,  16'h2000, 0, 0, LAT4};
        vecs[9]  = '{0, TICK_SENTINEL,   16'hFFFF, 0, 1, 1};
        vecs[10] = '{1, 28'd50_000_000,  16'h0999, 1, 0, LAT3};
        vecs[11] = '{1, 28'd49_950_000,  16'h0999, 0, 0, LAT3};
        vecs[12] = '{1, 28'd49_975_000,  16'h0999, 1, 0, LAT3};
        vecs[13] = '{1, TICK_SENTINEL,   16'h0FFF, 0, 1, 1};
        vecs[14] = '{1, 28'd12_500_000,  16'h0250, 0, 0, LAT3};
`else
        vecs[0]  = '{0, 28'd12_500_000,  16'h0250, 0, 0, LAT4};
        vecs[1]  = '{0, 28'd49_999,      16'h0000, 0, 0, LAT4};
        vecs[2]  = '{0, 28'd50_000,      16'h0001, 0, 0, LAT4};
        vecs[3]  = '{0, 28'd268_435_454, 16'h5368, 0, 0, LAT4};
        vecs[4]  = '{0, 28'd25_000,      16'h0000, 0, 0, LAT4};
        vecs[5]  = '{0, 28'd24_999,      16'h0000, 0, 0, LAT4};
        vecs[6]  = '{0, 28'd0,           16'h0000, 0, 0, LAT4};
        vecs[7]  = '{0, 28'd123_456_789, 16'h2469, 0, 0, LAT4};
        vecs[8]  = '{0, 28'd99_975_000,  16'h1999, 0, 0, LAT4};
        vecs[9]  = '{0, TICK_SENTINEL,   16'hFFFF, 0, 1, 1};
        vecs[10] = '{1, 28'd50_000_000,  16'h0999, 1, 0, LAT3};
        vecs[11] = '{1, 28'd49_950_000,  16'h0999, 0, 0, LAT3};
        vecs[12] = '{1, 28'd49_975_000,  16'h0999, 0, 0, LAT3};
        vecs[13] = '{1, TICK_SENTINEL,   16'h0FFF, 0, 1, 1};
        vecs[14] = '{1, 28'd12_500_000,  16'h0250, 0, 0, LAT3};
`endif

        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        ticks  = '0;
        ticks3 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset valid", valid, 1'b0);
        checkOutput("reset digits", digits, 16'h0000);
        checkOutput("reset ovf", ovf, 1'b0);
        checkOutput("reset none", none, 1'b0);
        checkOutput("reset digits3", digits3, 12'h000);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            runConversion($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ticks,
                          vecs[i].digits, vecs[i].ovf, vecs[i].none, vecs[i].lat);
        end

        // Starts while busy and in the valid cycle must both be dropped.
        valid_count  = 0;
        first_lat    = -1;
        first_digits = '0;
        applyStimulus(0, 28'd12_500_000);
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            start = 1'b0;
            ticks = '0;
            if (valid) begin
                valid_count++;
                if (first_lat < 0) begin
                    first_lat    = k;
                    first_digits = digits;
                end
            end
            if (k == 10 || valid) begin
                start = 1'b1;
                ticks = 28'd100_000;
            end
        end
        start = 1'b0;
        checkOutput("busy-start valid count", valid_count, 1);
        checkOutput("busy-start latency", first_lat, LAT4);
        checkOutput("busy-start digits", first_digits, 16'h0250);
        checkOutput("busy-start idle", busy, 1'b0);

        // Reset while the BCD engine is running.
        applyStimulus(0, 28'd12_500_000);
        repeat (34) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset digits", digits, 16'h0000);
        checkOutput("midreset valid", valid, 1'b0);
        rst_n = 1'b1;
        valid_count = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (valid) valid_count++;
        end
        checkOutput("midreset no valid", valid_count, 0);
        runConversion("after reset", 0, 28'd50_000, 16'h0001, 0, 0, LAT4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
